if_id_hazard_ctrl: RTL and testbench
====================================

Name: if_id_hazard_ctrl

Overview:
- Front-end sequencer for the 5-stage MIPS pipeline.
- Drives PC write enable, IF/ID write enable, IF/ID flush and ID/EX bubble-insert from four sources: load-use hazards, taken branches/jumps, instruction-memory wait and halt.
- Sits beside the IF/ID pipeline register and the PC register. Holds a small state machine and a saturating stall counter for lab performance reporting.

Parameters:
- FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken branch/jump (1..7).
- CNT_W, 16, width of the stall_count output.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- idex_memread  in  1  instruction in ID/EX is a load.
- idex_rt  in  5  destination register of the load in ID/EX.
- ifid_rs  in  5  rs field of the instruction in IF/ID.
- ifid_rt  in  5  rt field of the instruction in IF/ID.
- branch_taken  in  1  taken branch or jump resolved this cycle; PC mux already selects the target.
- imem_ready  in  1  instruction memory returns a valid instruction this cycle.
- halt  in  1  halt request, level.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  load NOP (32'h0) into IF/ID instead of instr; valid only with ifid_we=1.
- idex_bubble  out  1  zero the control bits entering ID/EX.
- state  out  2  current state: 0 RUN, 1 FLUSH, 2 IMEM_WAIT, 3 HALT.
- stall_count  out  CNT_W  saturating count of non-HALT cycles with pc_we=0.

Behaviour:
- Reset (rst_n=0, async): state=RUN, flush counter=0, stall_count=0. While reset is asserted: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0. Reset mid-FLUSH or mid-IMEM_WAIT abandons the sequence immediately.
- Outputs are combinational from the registered state plus the current inputs. state and stall_count update on the rising edge of clk.
- load_use = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt)).
- Priority in every non-HALT state: halt > branch_taken > !imem_ready > load_use > normal.
- halt (any state except reset):
  - all four outputs are 0 this cycle; next state is HALT.
  - HALT is sticky: outputs stay 0 and the only exit is rst_n.
- branch_taken (RUN, FLUSH or IMEM_WAIT):
  - pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1.
  - If FLUSH_CYCLES>1: next state FLUSH, flush counter=FLUSH_CYCLES-1. Otherwise next state RUN.
  - A new branch_taken during FLUSH restarts the counter.
- FLUSH, no higher-priority event:
  - pc_we=imem_ready, ifid_we=1, ifid_flush=1, idex_bubble=0.
  - Counter decrements only on cycles with imem_ready=1. When it reaches 0, next state is RUN.
- !imem_ready (RUN or IMEM_WAIT):
  - pc_we=0, ifid_we=1, ifid_flush=1, idex_bubble=0. The NOP enters IF/ID and the instruction already in ID proceeds.
  - Next state IMEM_WAIT.
- IMEM_WAIT with imem_ready=1: behaves as RUN for that cycle (load_use and normal rules apply); next state RUN.
- load_use (RUN, or IMEM_WAIT with imem_ready=1):
  - pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1.
  - Stays in RUN. The hazard clears naturally the next cycle once the load moves to MEM.
- normal: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- stall_count increments on each clock edge where state!=HALT, halt=0 and pc_we=0. It saturates at all-ones and does not wrap.
- load_use is ignored while in FLUSH, because IF/ID holds a NOP.
- Reset value is 0 for every output, including state and stall_count.

Test Plan:
- Reset then normal stream: imem_ready=1, no hazards for 10 cycles -> pc_we=ifid_we=1 every cycle; state=0; stall_count=0.
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle -> that cycle pc_we=0, ifid_we=0, idex_bubble=1. Next cycle normal; stall_count=1. Repeat with idex_rt=0 -> no stall.
- Branch with FLUSH_CYCLES=3: branch_taken pulse -> cycle 0 flush+bubble+pc_we=1, then 2 FLUSH cycles with ifid_flush=1, then RUN. Same cycle as a load_use -> branch wins.
- IMEM wait: imem_ready=0 for 4 cycles -> pc_we=0, ifid_flush=1, state=2; stall_count +4. A branch_taken arriving during the wait -> pc_we=1 and flush.
- Halt and reset: halt=1 mid-FLUSH -> all outputs 0, state=3, counter frozen. Drop halt -> stays HALT. rst_n=0 asynchronously (no clk edge) -> state=0, stall_count=0.
- Saturation: CNT_W=4, force 20 stall cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/if_id_hazard_ctrl.sv
// Front-end sequencer for the 5-stage pipeline: PC / IF/ID enables, IF/ID
// flush and ID/EX bubble from halt, taken branches, imem wait and load-use.
module if_id_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             halt,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_IMEM_WAIT = 2'd2,
    ST_HALT      = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_t     cur_state, nxt_state;
  logic [2:0] flush_cnt, nxt_flush_cnt;
  logic       load_use;

  assign load_use = idex_memread && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  assign state = cur_state;

  // State, flush counter and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= ST_RUN;
      flush_cnt   <= '0;
      stall_count <= '0;
    end else begin
      cur_state <= nxt_state;
      flush_cnt <= nxt_flush_cnt;
      if ((cur_state != ST_HALT) && !halt && !pc_we && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

  // Next-state and flush counter selection, priority halt > branch > wait > hazard
  always_comb begin
    nxt_state     = cur_state;
    nxt_flush_cnt = flush_cnt;
    if ((cur_state == ST_HALT) || halt) begin
      nxt_state = ST_HALT;
    end else if (branch_taken) begin
      nxt_state     = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
      nxt_flush_cnt = MULTI_FLUSH ? FLUSH_RELOAD : '0;
    end else if (cur_state == ST_FLUSH) begin
      // Counter only advances once a fetch actually completes
      if (imem_ready) begin
        nxt_flush_cnt = flush_cnt - 3'd1;
        if (flush_cnt == 3'd1)
          nxt_state = ST_RUN;
      end
    end else if (!imem_ready) begin
      nxt_state = ST_IMEM_WAIT;
    end else begin
      nxt_state = ST_RUN;
    end
  end

  // Pipeline control outputs from registered state and current inputs
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n || (cur_state == ST_HALT) || halt) begin
      pc_we = 1'b0;
    end else if (branch_taken) begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (cur_state == ST_FLUSH) begin
      pc_we      = imem_ready;
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
    end else if (!imem_ready) begin
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
    end else if (load_use) begin
      idex_bubble = 1'b1;
    end else begin
      pc_we   = 1'b1;
      ifid_we = 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench for if_id_hazard_ctrl (FLUSH_CYCLES=3, CNT_W=4).
module tb_if_id_hazard_ctrl;

  localparam int unsigned FC  = 3;
  localparam int unsigned CW  = 4;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          idex_memread;
  logic [4:0]    idex_rt, ifid_rs, ifid_rt;
  logic          branch_taken, imem_ready, halt;
  logic          pc_we, ifid_we, ifid_flush, idex_bubble;
  logic [1:0]    state;
  logic [CW-1:0] stall_count;

  if_id_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .halt(halt),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .state(state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] outs;   // {pc_we, ifid_we, ifid_flush, idex_bubble}
    logic [1:0] st;
    logic [3:0] sc;
  } exp_t;

  exp_t exp_q[$];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  int unsigned m_state = 0;
  int unsigned m_cnt   = 0;
  int unsigned m_stall = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, push model prediction, compare, advance model
  task automatic cyc(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                     input logic [4:0] rt, input logic bt, input logic rdy,
                     input logic h);
    exp_t e, got;
    logic lu;
    logic [3:0] o;
    int unsigned ns, nc;
    idex_memread = mr; idex_rt = xrt; ifid_rs = rs; ifid_rt = rt;
    branch_taken = bt; imem_ready = rdy; halt = h;
    lu = mr && (xrt != 0) && ((xrt == rs) || (xrt == rt));
    if (m_state == 3 || h)  o = 4'b0000;
    else if (bt)            o = 4'b1111;
    else if (m_state == 1)  o = {rdy, 3'b110};
    else if (!rdy)          o = 4'b0110;
    else if (lu)            o = 4'b0001;
    else                    o = 4'b1100;
    e.outs = o; e.st = 2'(m_state); e.sc = 4'(m_stall);
    exp_q.push_back(e);
    ns = m_state; nc = m_cnt;
    if (m_state == 3 || h) ns = 3;
    else if (bt) begin ns = (FC > 1) ? 1 : 0; nc = FC - 1; end
    else if (m_state == 1) begin
      if (rdy) begin nc = m_cnt - 1; ns = (nc == 0) ? 0 : 1; end
    end else ns = rdy ? 0 : 2;
    #2;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      got = exp_q.pop_front();
      check("outs", {pc_we, ifid_we, ifid_flush, idex_bubble}, got.outs);
      check("state", state, got.st);
      check("stall_count", stall_count, got.sc);
    end
    if (m_state != 3 && !h && !o[3] && m_stall < SAT) m_stall++;
    @(posedge clk); #1;
    m_state = ns; m_cnt = nc;
  endtask

  task automatic normal(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    branch_taken = 0; imem_ready = 1; halt = 0;
    #1;
    check("rst_outs", {pc_we, ifid_we, ifid_flush, idex_bubble}, 0);
    check("rst_state", state, 0);
    check("rst_stall", stall_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal stream
    normal(10);
    check("normal_stall", stall_count, 0);

    // Load-use stall, then idex_rt=0 (no hazard)
    cyc(1, 8, 8, 3, 0, 1, 0);
    normal(1);
    check("lu_stall", stall_count, 1);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 9, 2, 9, 0, 1, 0);   // rt match also stalls
    normal(1);
    check("lu_stall2", stall_count, 2);

    // Branch: cycle 0 then 2 FLUSH cycles then RUN
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("br_state_flush", state, 1);
    normal(2);
    check("br_state_run", state, 0);
    // Branch wins over simultaneous load-use; load-use ignored in FLUSH
    cyc(1, 8, 8, 0, 1, 1, 0);
    cyc(1, 8, 8, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);   // FLUSH stalled on imem, no decrement
    normal(2);
    check("flush_wait_stall", stall_count, 3);

    // Imem wait for 4 cycles
    for (int unsigned i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    check("imem_state", state, 2);
    normal(1);
    check("imem_stall", stall_count, 7);

    // Branch during wait, then halt mid-FLUSH
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    check("halt_state", state, 3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 8, 8, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("halt_stall_frozen", stall_count, 8);

    // Asynchronous reset without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_stall", stall_count, 0);
    check("async_rst_outs", {pc_we, ifid_we, ifid_flush, idex_bubble}, 0);
    m_state = 0; m_cnt = 0; m_stall = 0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Saturation: 20 stall cycles
    for (int unsigned i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    check("sat_stall", stall_count, SAT);

    // Random mix without halt
    for (int unsigned i = 0; i < 200; i++)
      cyc($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
